instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Pipeline stage 1 (IF) of the 5-stage RV32I ALU pipeline. It sits directly upstream of instruction_decode and feeds it instruction_1, PC_1 and prev_taken_1. It owns the PC, the I-cache read handshake, a static-target / 2-bit-counter branch predictor, and redirect on mispredict from EX. It also generates the flush pulse to decode and holds a pending redirect across I-cache misses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0013, bubble loaded into the IF/ID register (addi x0,x0,0)
CNT_INIT, 2'b01, reset value of the 2-bit prediction counter (weakly not-taken)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
ICACHE_ren  out  1  I-cache read request
ICACHE_addr  out  30  word address, PC_r[31:2]
ICACHE_rdata  in  32  fetched instruction in instruction bit order, valid when ICACHE_stall=0
ICACHE_stall  in  1  I-cache miss in progress; rdata not valid
memory_stall  in  1  D-cache stall; whole pipeline frozen
hazard_stall  in  1  load-use stall from decode (its PC_write); 1 = hold PC and IF/ID
branch_resolved  in  1  EX resolved a conditional branch this cycle
branch_taken  in  1  actual outcome of that branch
mispredict  in  1  EX detected a wrong fetch path
branch_target  in  32  correct PC after mispredict
instruction_1  out  32  IF/ID instruction
PC_1  out  32  IF/ID PC
prev_taken_1  out  1  fetch predicted taken for instruction_1
flush  out  1  combinational: mispredict & ~memory_stall; decode squashes its input

Behaviour:
- Reset (async, any time, including mid-miss or mid-redirect): PC_r=RESET_PC, instruction_1=NOP_INST, PC_1=0, prev_taken_1=0, counter=CNT_INIT, state=NORMAL, pending_pc=0. ICACHE_ren=0 while rst=1 and 1 at all other times.
- Predecode of ICACHE_rdata:
  - B-type (opcode 1100011): predict taken iff counter[1]; target = PC_r + B-imm (sign-extended, bit0=0).
  - JAL (1101111): always taken; target = PC_r + J-imm.
  - JALR and all others: not taken; next = PC_r + 4.
  - 32-bit adds wrap modulo 2^32.
- Advance condition: adv = ~ICACHE_stall & ~memory_stall & ~hazard_stall & ~redirect. When adv=1: IF/ID <= {rdata, PC_r, pred_taken}; PC_r <= pred target or PC_r+4. Latency: one cycle from PC_r to instruction_1.
- redirect = mispredict & ~memory_stall. Priority: rst > redirect > stall hold.
  - If redirect and ICACHE_stall=0: PC_r <= branch_target; IF/ID <= NOP_INST with prev_taken_1=0; state stays NORMAL.
  - If redirect and ICACHE_stall=1: pending_pc <= branch_target; state <= REDIRECT_WAIT; IF/ID <= NOP_INST.
- FSM:
  - NORMAL: behaves as above.
  - REDIRECT_WAIT: IF/ID is held at NOP_INST and the returned word is discarded. On the first cycle with ICACHE_stall=0: PC_r <= pending_pc, state <= NORMAL. A new redirect in this state overwrites pending_pc.
- Counter: updated when branch_resolved & ~memory_stall; saturating +1 on taken, -1 on not taken. Holds at 11 and at 00. Update and predict in the same cycle: the prediction uses the pre-update value.
- memory_stall=1: all state holds, including counter and pending_pc; flush=0.
- hazard_stall with ICACHE_stall: hold, no double fetch.

Test Plan:
- Reset release, no stalls, ICACHE returns addi words -> ICACHE_addr 0,1,2...; instruction_1 lags one cycle; PC_1 = 0,4,8.
- Word at PC 0x10 is JAL x1,+0x20 -> next ICACHE_addr = 0x30>>2 = 0xC; prev_taken_1=1 with PC_1=0x10.
- BEQ at 0x40, offset -8, counter=01 -> not taken (next PC 0x44). Two branch_resolved taken pulses -> counter=11; next fetch of the same BEQ goes to 0x38 with prev_taken_1=1.
- mispredict=1, branch_target=0x100, ICACHE_stall=0 -> flush=1 that cycle; instruction_1=0x00000013 next cycle; ICACHE_addr=0x40.
- mispredict with ICACHE_stall=1 for 3 cycles -> REDIRECT_WAIT; returned word discarded; then ICACHE_addr=0x40 (PC 0x100); instruction_1 stays NOP until the fetch from 0x100.
- memory_stall and hazard_stall each held 2 cycles, plus rst pulsed mid-miss -> PC and IF/ID unchanged during the stalls; on reset all outputs return to reset values immediately (async).

Source files
------------

// File: rtl/instruction_fetch_if.sv
// I-cache read port between the fetch stage (master) and the instruction cache (slave).
interface instruction_fetch_if;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;

  modport master (
    output ICACHE_ren,
    output ICACHE_addr,
    input  ICACHE_rdata,
    input  ICACHE_stall
  );

  modport slave (
    input  ICACHE_ren,
    input  ICACHE_addr,
    output ICACHE_rdata,
    output ICACHE_stall
  );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage RV32I pipeline: PC, I-cache read, static-target / 2-bit
// counter branch prediction, and mispredict redirect that survives I-cache misses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_if.master        icache,
  input  logic                       memory_stall,
  input  logic                       hazard_stall,
  input  logic                       branch_resolved,
  input  logic                       branch_taken,
  input  logic                       mispredict,
  input  logic [31:0]                branch_target,
  output logic [31:0]                instruction_1,
  output logic [31:0]                PC_1,
  output logic                       prev_taken_1,
  output logic                       flush
);

  typedef enum logic [0:0] {
    ST_NORMAL        = 1'b0,
    ST_REDIRECT_WAIT = 1'b1
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [31:0] f_b_imm(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] f_j_imm(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic [1:0]  r_cnt;

  logic        w_redirect;
  logic        w_adv;
  logic        w_pred_taken;
  logic [31:0] w_next_pc;
  logic [6:0]  w_opcode;

  assign icache.ICACHE_ren  = ~rst;
  assign icache.ICACHE_addr = r_pc[31:2];
  assign w_opcode           = icache.ICACHE_rdata[6:0];
  assign w_redirect         = mispredict & ~memory_stall;
  assign flush              = w_redirect;
  assign w_adv              = ~icache.ICACHE_stall & ~memory_stall & ~hazard_stall & ~w_redirect;

  // Predecode the returned word; the counter read here is the pre-update value.
  always_comb begin
    w_pred_taken = 1'b0;
    w_next_pc    = r_pc + 32'd4;
    case (w_opcode)
      OP_BRANCH: begin
        if (r_cnt[1]) begin
          w_pred_taken = 1'b1;
          w_next_pc    = r_pc + f_b_imm(icache.ICACHE_rdata);
        end else begin
          w_pred_taken = 1'b0;
          w_next_pc    = r_pc + 32'd4;
        end
      end
      OP_JAL: begin
        w_pred_taken = 1'b1;
        w_next_pc    = r_pc + f_j_imm(icache.ICACHE_rdata);
      end
      default: begin
        w_pred_taken = 1'b0;
        w_next_pc    = r_pc + 32'd4;
      end
    endcase
  end

  // PC, IF/ID register, predictor counter and redirect FSM; memory_stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_pending_pc  <= 32'h0000_0000;
      r_cnt         <= CNT_INIT;
      r_state       <= ST_NORMAL;
      instruction_1 <= NOP_INST;
      PC_1          <= 32'h0000_0000;
      prev_taken_1  <= 1'b0;
    end else if (!memory_stall) begin
      if (branch_resolved) begin
        if (branch_taken) begin
          r_cnt <= (r_cnt == 2'b11) ? 2'b11 : r_cnt + 2'd1;
        end else begin
          r_cnt <= (r_cnt == 2'b00) ? 2'b00 : r_cnt - 2'd1;
        end
      end
      case (r_state)
        ST_NORMAL: begin
          if (w_redirect) begin
            instruction_1 <= NOP_INST;
            prev_taken_1  <= 1'b0;
            if (!icache.ICACHE_stall) begin
              r_pc <= branch_target;
            end else begin
              // The miss in flight belongs to the wrong path; remember where to go.
              r_pending_pc <= branch_target;
              r_state      <= ST_REDIRECT_WAIT;
            end
          end else if (w_adv) begin
            instruction_1 <= icache.ICACHE_rdata;
            PC_1          <= r_pc;
            prev_taken_1  <= w_pred_taken;
            r_pc          <= w_next_pc;
          end
        end
        ST_REDIRECT_WAIT: begin
          instruction_1 <= NOP_INST;
          prev_taken_1  <= 1'b0;
          if (!icache.ICACHE_stall) begin
            r_pc    <= w_redirect ? branch_target : r_pending_pc;
            r_state <= ST_NORMAL;
          end else if (w_redirect) begin
            r_pending_pc <= branch_target;
          end
        end
        default: begin
          r_state <= ST_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a PC-level reference model predicts the IF/ID
// register, the fetch address and flush; a negedge monitor compares against the DUT.
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int K_ALU = 0, K_BR = 1, K_JAL = 2, K_OTHER = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_stall, hazard_stall, branch_resolved, branch_taken, mispredict;
  logic [31:0] branch_target;
  logic [31:0] instruction_1, PC_1;
  logic        prev_taken_1, flush;

  instruction_fetch_if ic_if ();

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013),
    .CNT_INIT (2'b01)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .icache          (ic_if),
    .memory_stall    (memory_stall),
    .hazard_stall    (hazard_stall),
    .branch_resolved (branch_resolved),
    .branch_taken    (branch_taken),
    .mispredict      (mispredict),
    .branch_target   (branch_target),
    .instruction_1   (instruction_1),
    .PC_1            (PC_1),
    .prev_taken_1    (prev_taken_1),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  // Program memory: encoded word plus the meaning the model uses (kind, byte offset).
  logic [31:0] mem_word [256];
  int          mem_kind [256];
  int          mem_off  [256];

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic void set_word(input int i, input int kind, input int off, input logic [31:0] w);
    mem_word[i] = w;
    mem_kind[i] = kind;
    mem_off[i]  = off;
  endfunction

  function automatic void set_alu(input int i, input int n);
    logic [11:0] im;
    im = n[11:0];
    set_word(i, K_ALU, 0, {im, 5'd0, 3'b000, 5'd1, 7'b0010011});
  endfunction

  // Reference model state: architectural view, not the RTL's encoding.
  logic [31:0] m_pc, m_pending, m_ins, m_pc1;
  bit          m_wait, m_pt;
  int          m_cnt;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc1;
    logic        pt;
    logic [29:0] addr;
    logic        ren;
  } exp_t;

  exp_t q_state[$];
  bit   q_flush[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void model_reset();
    m_pc = 32'h0; m_pending = 32'h0; m_ins = NOP; m_pc1 = 32'h0;
    m_wait = 1'b0; m_pt = 1'b0; m_cnt = 1;
  endfunction

  function automatic void model_step(input bit ic, input bit ms, input bit hz, input bit br,
                                     input bit bt, input bit mp, input logic [31:0] tgt);
    int  i;
    bit  taken;
    if (ms) return;
    i = int'(m_pc[9:2]);
    if (m_wait) begin
      if (mp && !ic) begin m_pc = tgt; m_wait = 1'b0; end
      else if (mp) m_pending = tgt;
      else if (!ic) begin m_pc = m_pending; m_wait = 1'b0; end
    end else if (mp) begin
      m_ins = NOP; m_pt = 1'b0;
      if (!ic) m_pc = tgt;
      else begin m_pending = tgt; m_wait = 1'b1; end
    end else if (!ic && !hz) begin
      taken = (mem_kind[i] == K_JAL) || (mem_kind[i] == K_BR && m_cnt >= 2);
      m_ins = mem_word[i]; m_pc1 = m_pc; m_pt = taken;
      m_pc  = taken ? m_pc + 32'(mem_off[i]) : m_pc + 32'd4;
    end
    if (br) m_cnt = bt ? ((m_cnt == 3) ? 3 : m_cnt + 1) : ((m_cnt == 0) ? 0 : m_cnt - 1);
  endfunction

  function automatic void push_state();
    exp_t e;
    e.ins = m_ins; e.pc1 = m_pc1; e.pt = m_pt; e.addr = m_pc[31:2]; e.ren = ~rst;
    q_state.push_back(e);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares the registered outputs and the combinational flush every negedge.
  exp_t mon_e;
  bit   mon_f;
  always @(negedge clk) begin
    if (q_state.size() != 0) begin
      mon_e = q_state.pop_front();
      check("instruction_1", instruction_1, mon_e.ins);
      check("PC_1", PC_1, mon_e.pc1);
      check("prev_taken_1", {31'd0, prev_taken_1}, {31'd0, mon_e.pt});
      check("ICACHE_addr", {2'b00, ic_if.ICACHE_addr}, {2'b00, mon_e.addr});
      check("ICACHE_ren", {31'd0, ic_if.ICACHE_ren}, {31'd0, mon_e.ren});
    end
    if (q_flush.size() != 0) begin
      mon_f = q_flush.pop_front();
      check("flush", {31'd0, flush}, {31'd0, mon_f});
    end
  end

  task automatic tick(input bit ic, input bit ms, input bit hz, input bit br, input bit bt,
                      input bit mp, input logic [31:0] tgt);
    ic_if.ICACHE_stall   = ic;
    ic_if.ICACHE_rdata   = mem_word[m_pc[9:2]];
    memory_stall         = ms;
    hazard_stall         = hz;
    branch_resolved      = br;
    branch_taken         = bt;
    mispredict           = mp;
    branch_target        = tgt;
    q_flush.push_back(mp & ~ms);
    @(posedge clk);
    model_step(ic, ms, hz, br, bt, mp, tgt);
    #1;
    push_state();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Reset asserted between edges while a miss is outstanding; outputs must clear at once.
  task automatic async_reset_mid_miss();
    ic_if.ICACHE_stall = 1'b1;
    memory_stall = 1'b0; hazard_stall = 1'b0; branch_resolved = 1'b0;
    branch_taken = 1'b0; mispredict = 1'b0;
    q_flush.push_back(1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    push_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_state();
  endtask

  function automatic void fill_random();
    logic [31:0] w;
    int          r;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 99));
      w = $urandom;
      if (r < 55) set_alu(i, int'(w[11:0]));
      else if (r < 75) begin
        r = 4 * (int'($urandom_range(0, 32)) - 16);
        set_word(i, K_BR, r, enc_b(r));
      end else if (r < 85) begin
        r = 4 * (int'($urandom_range(0, 128)) - 64);
        set_word(i, K_JAL, r, enc_j(r));
      end else if (r < 92) begin
        set_word(i, K_OTHER, 0, {w[31:20], 5'd1, 3'b000, 5'd1, 7'b1100111});
      end else begin
        w[6:0] = (w[7]) ? 7'b0110011 : 7'b0000011;
        set_word(i, K_OTHER, 0, w);
      end
    end
  endfunction

  initial begin
    rst = 1'b1;
    memory_stall = 1'b0; hazard_stall = 1'b0; branch_resolved = 1'b0;
    branch_taken = 1'b0; mispredict = 1'b0; branch_target = 32'h0;
    ic_if.ICACHE_stall = 1'b0; ic_if.ICACHE_rdata = 32'h0;
    for (int i = 0; i < 256; i++) set_alu(i, i);
    set_word(4, K_JAL, 32'h20, enc_j(32'h20));
    set_word(16, K_BR, -8, enc_b(-8));
    model_reset();
    #1;
    push_state();
    q_flush.push_back(1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_state();

    // Straight-line fetch, JAL at 0x10, BEQ at 0x40 predicted not taken.
    idle(12);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    // Redirect back to the BEQ, now predicted taken to 0x38.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    idle(6);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    idle(3);
    // Redirect during a 3-cycle miss.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(3);
    // Memory stall (mispredict masked), hazard stall, hazard during a miss.
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(2);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    async_reset_mid_miss();
    idle(4);

    fill_random();
    for (int k = 0; k < 800; k++) begin
      tick($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 20, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 8,
           {22'd0, 8'($urandom_range(0, 255)), 2'b00});
      if (k == 400) async_reset_mid_miss();
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
